i2c_config_seq: RTL and testbench

- Power-up configuration sequencer for the I2C write master.
- Walks an external table of 24-bit write entries {slave_addr, sub_addr, data}. Launches one I2C write per entry and checks the returned ack error. Retries failed writes and reports overall completion or failure.
- Sits between the codec/camera register ROM and the I2C master's dstream_i2c port. Runs on the same 20 kHz clock as the master.

---
 rtl/i2c_config_seq.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_config_seq.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_config_seq.sv
// Power-up configuration sequencer: walks a register table and issues
// one I2C write per entry, with retries and a timeout per write.
module i2c_config_seq #(
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = 4,
    parameter int PWR_DELAY  = 200,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 64,
    parameter int MAX_RETRY  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    output logic [IDX_W-1:0] cfg_index,
    input  logic [23:0]      cfg_entry,
    output logic             i2c_start,
    output logic [23:0]      i2c_data,
    input  logic             i2c_done,
    input  logic             i2c_error,
    output logic             busy,
    output logic             cfg_done,
    output logic             cfg_error,
    output logic [IDX_W-1:0] err_index
);

    localparam int M1      = (PWR_DELAY > TIMEOUT) ? PWR_DELAY : TIMEOUT;
    localparam int CNT_MAX = (M1 > GAP_CYCLES) ? M1 : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 2);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_DELAY - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_PWR_WAIT,
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_DONE,
        S_RETRY,
        S_GAP_OK,
        S_GAP_RETRY,
        S_FINISH,
        S_FAIL
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic [23:0]        data_q, data_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               ok_q, ok_d;
    logic               err_q, err_d;
    logic               done_q;
    logic               done_rise;

    // Only the rising edge of the master's done level completes a write.
    assign done_rise = i2c_done & ~done_q;

    assign cfg_index = idx_q;
    assign i2c_start = start_q;
    assign i2c_data  = data_q;
    assign busy      = busy_q;
    assign cfg_done  = ok_q;
    assign cfg_error = err_q;
    assign err_index = err_idx_q;

    // State and datapath registers; reset lands in the power-up delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_PWR_WAIT;
            cnt_q     <= '0;
            retry_q   <= '0;
            idx_q     <= '0;
            err_idx_q <= '0;
            data_q    <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b1;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            data_q    <= data_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            done_q    <= i2c_done;
        end
    end

    // Next-state logic for the table walk, retry and timeout handling.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        idx_d     = idx_q;
        err_idx_d = err_idx_q;
        data_d    = data_q;
        busy_d    = busy_q;
        ok_d      = ok_q;
        err_d     = err_q;

        case (state_q)
            S_PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (go) begin
                    idx_d   = '0;
                    retry_d = '0;
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cfg_entry == 24'h000000) begin
                    state_d = S_FINISH;
                end else begin
                    data_d  = cfg_entry;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_rise) begin
                    cnt_d   = '0;
                    state_d = i2c_error ? S_RETRY : S_GAP_OK;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_RETRY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RETRY: begin
                if (retry_q < RTY_MAX) begin
                    retry_d = retry_q + RTY_W'(1);
                    cnt_d   = '0;
                    state_d = S_GAP_RETRY;
                end else begin
                    err_idx_d = idx_q;
                    err_d     = 1'b1;
                    state_d   = S_FAIL;
                end
            end
            S_GAP_OK: begin
                if (cnt_q == GAP_LAST) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        retry_d = '0;
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP_RETRY: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FINISH: begin
                ok_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // START lasts one cycle, so the pulse can never stretch to two.
        start_d = (state_d == S_START);
    end

endmodule

// File: tb/tb_i2c_config_seq.sv
// Scoreboard bench for i2c_config_seq with a behavioural I2C master
// that can ack, NACK a chosen entry, or hang without done.
`timescale 1ns/1ps
module tb_i2c_config_seq;

    localparam int NUM_REGS   = 3;
    localparam int IDX_W      = 4;
    localparam int PWR_DELAY  = 200;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 64;
    localparam int MAX_RETRY  = 3;
    localparam int XFER       = 10;

    logic             clk;
    logic             rst_n;
    logic             go;
    logic [IDX_W-1:0] cfg_index;
    logic [23:0]      cfg_entry;
    logic             i2c_start;
    logic [23:0]      i2c_data;
    logic             i2c_done;
    logic             i2c_error;
    logic             busy;
    logic             cfg_done;
    logic             cfg_error;
    logic [IDX_W-1:0] err_index;

    logic [23:0] tbl [16];
    logic [23:0] exp_q [$];
    int          start_cyc_q [$];
    int          nack_left [16];
    int          cyc = 0;
    int          last_done_cyc = -1000;
    int          rel_cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          hang = 0;
    bit          prev_start = 0;

    i2c_config_seq #(
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W),
        .PWR_DELAY (PWR_DELAY),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .cfg_index(cfg_index),
        .cfg_entry(cfg_entry),
        .i2c_start(i2c_start),
        .i2c_data (i2c_data),
        .i2c_done (i2c_done),
        .i2c_error(i2c_error),
        .busy     (busy),
        .cfg_done (cfg_done),
        .cfg_error(cfg_error),
        .err_index(err_index)
    );

    assign cfg_entry = tbl[cfg_index];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Start monitor: pops the scoreboard on every start pulse.
    always @(negedge clk) begin
        logic [23:0] e;
        if (rst_n === 1'b1 && i2c_start === 1'b1) begin
            n_checks++;
            if (prev_start) begin
                n_fail++;
                $display("FAIL start_width: start high two cycles, cyc %0d", cyc);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL start_data: unexpected start data %h", i2c_data);
            end else begin
                e = exp_q.pop_front();
                if (i2c_data !== e) begin
                    n_fail++;
                    $display("FAIL start_data: got %h want %h", i2c_data, e);
                end
            end
            n_checks++;
            // done edge is registered, then GAP_CYCLES idle cycles follow
            if (cyc - last_done_cyc < GAP_CYCLES + 1) begin
                n_fail++;
                $display("FAIL start_gap: got %0d want >= %0d",
                         cyc - last_done_cyc, GAP_CYCLES + 1);
            end
            start_cyc_q.push_back(cyc);
        end
        prev_start = (i2c_start === 1'b1);
    end

    // Master model: done level for 2 cycles, XFER cycles after start.
    initial begin
        int  idx;
        bit  err;
        i2c_done  = 1'b0;
        i2c_error = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && i2c_start === 1'b1 && !hang) begin
                idx = int'(cfg_index);
                err = (nack_left[idx] > 0);
                if (err) nack_left[idx]--;
                repeat (XFER) @(negedge clk);
                i2c_done      = 1'b1;
                i2c_error     = err;
                last_done_cyc = cyc;
                repeat (2) @(negedge clk);
                i2c_done  = 1'b0;
                i2c_error = 1'b0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic run_pass(output bit ok);
        int t;
        ok = 1;
        @(negedge clk);
        t = 0;
        while (busy !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) ok = 0;
        go = 1'b1;
        @(negedge clk);
        t = 0;
        while (busy !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) ok = 0;
        go = 1'b0;
        t = 0;
        while (busy !== 1'b0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) ok = 0;
    endtask

    task automatic test_reset();
        logic [33:0] got;
        rst_n = 1'b0;
        go    = 1'b0;
        repeat (3) @(negedge clk);
        got = {i2c_start, i2c_data, cfg_index, busy, cfg_done, cfg_error};
        n_checks++;
        if (got !== {1'b0, 24'h0, 4'h0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_vals: got %h want %h", got,
                     {1'b0, 24'h0, 4'h0, 1'b1, 1'b0, 1'b0});
        end
        n_checks++;
        if (err_index !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_err_index: got %h want 0", err_index);
        end
        go    = 1'b1;
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic test_clean_pass();
        bit ok;
        start_cyc_q.delete();
        for (int i = 0; i < NUM_REGS; i++) exp_q.push_back(tbl[i]);
        run_pass(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL clean_handshake: got timeout want pass end");
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL clean_count: got %0d missing want 0", exp_q.size());
        end
        n_checks++;
        if (start_cyc_q.size() == 0 || start_cyc_q[0] - rel_cyc < PWR_DELAY) begin
            n_fail++;
            $display("FAIL pwr_delay: got first start too early want >= %0d",
                     PWR_DELAY);
        end
        n_checks++;
        if ({cfg_done, busy, cfg_error} !== 3'b100) begin
            n_fail++;
            $display("FAIL clean_flags: got %b want 100",
                     {cfg_done, busy, cfg_error});
        end
        n_checks++;
        if (cfg_index !== 4'(NUM_REGS - 1)) begin
            n_fail++;
            $display("FAIL index_limit: got %0d want %0d", cfg_index,
                     NUM_REGS - 1);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_nack_retry();
        bit ok;
        start_cyc_q.delete();
        nack_left[1] = 2;
        exp_q.push_back(tbl[0]);
        repeat (3) exp_q.push_back(tbl[1]);
        exp_q.push_back(tbl[2]);
        run_pass(ok);
        n_checks++;
        if (!ok || exp_q.size() != 0 || start_cyc_q.size() != 5) begin
            n_fail++;
            $display("FAIL retry_starts: got %0d starts want 5",
                     start_cyc_q.size());
        end
        n_checks++;
        if ({cfg_done, cfg_error} !== 2'b10) begin
            n_fail++;
            $display("FAIL retry_flags: got %b want 10", {cfg_done, cfg_error});
        end
        nack_left[1] = 0;
    endtask

    task automatic test_nack_fail();
        bit ok;
        start_cyc_q.delete();
        nack_left[2] = 100;
        exp_q.push_back(tbl[0]);
        exp_q.push_back(tbl[1]);
        repeat (MAX_RETRY + 1) exp_q.push_back(tbl[2]);
        run_pass(ok);
        repeat (30) @(negedge clk);
        n_checks++;
        if (!ok || exp_q.size() != 0 || start_cyc_q.size() != MAX_RETRY + 3) begin
            n_fail++;
            $display("FAIL fail_starts: got %0d starts want %0d",
                     start_cyc_q.size(), MAX_RETRY + 3);
        end
        n_checks++;
        if ({cfg_done, cfg_error, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL fail_flags: got %b want 010",
                     {cfg_done, cfg_error, busy});
        end
        n_checks++;
        if (err_index !== 4'd2) begin
            n_fail++;
            $display("FAIL fail_err_index: got %0d want 2", err_index);
        end
        nack_left[2] = 0;
    endtask

    task automatic test_timeout();
        bit ok;
        int d;
        start_cyc_q.delete();
        hang = 1;
        repeat (MAX_RETRY + 1) exp_q.push_back(tbl[0]);
        run_pass(ok);
        hang = 0;
        n_checks++;
        if (!ok || start_cyc_q.size() != MAX_RETRY + 1) begin
            n_fail++;
            $display("FAIL to_starts: got %0d want %0d", start_cyc_q.size(),
                     MAX_RETRY + 1);
        end
        for (int i = 1; i < start_cyc_q.size(); i++) begin
            d = start_cyc_q[i] - start_cyc_q[i-1];
            n_checks++;
            // START + TIMEOUT waits + RETRY + gap
            if (d != TIMEOUT + GAP_CYCLES + 2) begin
                n_fail++;
                $display("FAIL to_interval%0d: got %0d want %0d", i, d,
                         TIMEOUT + GAP_CYCLES + 2);
            end
        end
        n_checks++;
        if ({cfg_error, cfg_done, err_index} !== {2'b10, 4'd0}) begin
            n_fail++;
            $display("FAIL to_flags: got %b/%0d want 10/0",
                     {cfg_error, cfg_done}, err_index);
        end
    endtask

    task automatic test_end_marker();
        bit ok;
        logic [23:0] save;
        save   = tbl[1];
        tbl[1] = 24'h000000;
        start_cyc_q.delete();
        exp_q.push_back(tbl[0]);
        run_pass(ok);
        n_checks++;
        if (!ok || exp_q.size() != 0 || start_cyc_q.size() != 1) begin
            n_fail++;
            $display("FAIL marker_starts: got %0d want 1", start_cyc_q.size());
        end
        n_checks++;
        if ({cfg_done, cfg_error, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL marker_flags: got %b want 100",
                     {cfg_done, cfg_error, busy});
        end
        tbl[1] = save;
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        bit bad;
        int t;
        logic [33:0] got;
        start_cyc_q.delete();
        exp_q.push_back(tbl[0]);
        go = 1'b1;
        t = 0;
        while (start_cyc_q.size() == 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        go = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        got = {i2c_start, i2c_data, cfg_index, busy, cfg_done, cfg_error};
        n_checks++;
        if (got !== {1'b0, 24'h0, 4'h0, 1'b1, 1'b0, 1'b0} ||
            err_index !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h/%h want %h/0", got, err_index,
                     {1'b0, 24'h0, 4'h0, 1'b1, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
        bad = 0;
        repeat (PWR_DELAY - 2) begin
            @(negedge clk);
            if (busy !== 1'b1 || cfg_done !== 1'b0 || cfg_error !== 1'b0)
                bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL pwr_absorb: got state change want busy=1 idle flags");
        end
        start_cyc_q.delete();
        for (int i = 0; i < NUM_REGS; i++) exp_q.push_back(tbl[i]);
        run_pass(ok);
        n_checks++;
        if (!ok || exp_q.size() != 0 || start_cyc_q.size() != NUM_REGS) begin
            n_fail++;
            $display("FAIL restart_starts: got %0d want %0d",
                     start_cyc_q.size(), NUM_REGS);
        end
        n_checks++;
        if ({cfg_done, cfg_error} !== 2'b10) begin
            n_fail++;
            $display("FAIL restart_flags: got %b want 10", {cfg_done, cfg_error});
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i]       = 24'h000000;
            nack_left[i] = 0;
        end
        tbl[0] = 24'h123456;
        tbl[1] = 24'h1A02FF;
        tbl[2] = 24'h341001;
        tbl[3] = 24'h56789A;
        test_reset();
        test_clean_pass();
        test_nack_retry();
        test_nack_fail();
        test_timeout();
        test_end_marker();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
